// File: rtl/parse_act_cfg_ctrl.sv
// Control-stream controller that turns claimed config packets into one parser action RAM write.
// Optional `PARSE_CFG_ERR_CNT_EN adds a saturating malformed-packet counter output.
module parse_act_cfg_ctrl #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH = 256,
  parameter logic [7:0]  C_MOD_ID            = 8'h01,
  parameter int unsigned C_RAM_WIDTH         = 260,
  parameter int unsigned C_RAM_AW            = 4
) (
  input  logic                             axis_clk,
  input  logic                             areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_ctrl_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_ctrl_tkeep,
  input  logic                             s_ctrl_tvalid,
  input  logic                             s_ctrl_tlast,
  output logic                             s_ctrl_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]   m_ctrl_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0] m_ctrl_tkeep,
  output logic                             m_ctrl_tvalid,
  output logic                             m_ctrl_tlast,
  input  logic                             m_ctrl_tready,
  input  logic                             parser_busy,
  output logic [C_RAM_AW-1:0]              ram_addr,
  output logic [C_RAM_WIDTH-1:0]           ram_din,
  output logic                             ram_en,
  output logic                             ram_we
`ifdef PARSE_CFG_ERR_CNT_EN
  ,
  output logic [15:0]                      cfg_err_cnt
`endif
);

  localparam int unsigned LowW  = C_S_AXIS_DATA_WIDTH - 32;
  localparam int unsigned HighW = C_RAM_WIDTH - LowW;

  typedef enum logic [2:0] {StIdle, StCap, StCommit, StFwd, StDrop} state_e;

  state_e              state_q;
  logic [C_RAM_AW-1:0] idx_q;
  logic [LowW-1:0]     low_q;
  logic                fwd_rdy;
  logic                claimed;
  logic                accept;

  assign fwd_rdy = !m_ctrl_tvalid || m_ctrl_tready;
  assign claimed = (s_ctrl_tdata[7:0] == C_MOD_ID) && (s_ctrl_tdata[15:12] == 4'h0);
  assign accept  = s_ctrl_tvalid && s_ctrl_tready;

  always_comb begin
    s_ctrl_tready = 1'b0;
    unique case (state_q)
      StIdle, StFwd: s_ctrl_tready = fwd_rdy;
      StCap, StDrop: s_ctrl_tready = 1'b1;
      StCommit:      s_ctrl_tready = 1'b0;
      default:       s_ctrl_tready = 1'b0;
    endcase
  end

  // The write strobe tracks parser_busy combinationally so it lands exactly on the first idle cycle.
  assign ram_en = (state_q == StCommit) && !parser_busy && !areset;
  assign ram_we = ram_en;

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      low_q         <= '0;
      ram_addr      <= '0;
      ram_din       <= '0;
      m_ctrl_tdata  <= '0;
      m_ctrl_tkeep  <= '0;
      m_ctrl_tvalid <= 1'b0;
      m_ctrl_tlast  <= 1'b0;
    end else begin
      if (m_ctrl_tvalid && m_ctrl_tready) m_ctrl_tvalid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (claimed) begin
              if (!s_ctrl_tlast) begin
                idx_q   <= s_ctrl_tdata[8 +: C_RAM_AW];
                low_q   <= s_ctrl_tdata[C_S_AXIS_DATA_WIDTH-1:32];
                state_q <= StCap;
              end
            end else begin
              m_ctrl_tdata  <= s_ctrl_tdata;
              m_ctrl_tkeep  <= s_ctrl_tkeep;
              m_ctrl_tlast  <= s_ctrl_tlast;
              m_ctrl_tvalid <= 1'b1;
              if (!s_ctrl_tlast) state_q <= StFwd;
            end
          end
        end
        StCap: begin
          if (s_ctrl_tvalid) begin
            if (s_ctrl_tlast) begin
              ram_addr <= idx_q;
              ram_din  <= {s_ctrl_tdata[HighW-1:0], low_q};
              state_q  <= StCommit;
            end else begin
              state_q <= StDrop;
            end
          end
        end
        StCommit: begin
          if (!parser_busy) state_q <= StIdle;
        end
        StFwd: begin
          if (accept) begin
            m_ctrl_tdata  <= s_ctrl_tdata;
            m_ctrl_tkeep  <= s_ctrl_tkeep;
            m_ctrl_tlast  <= s_ctrl_tlast;
            m_ctrl_tvalid <= 1'b1;
            if (s_ctrl_tlast) state_q <= StIdle;
          end
        end
        StDrop: begin
          if (s_ctrl_tvalid && s_ctrl_tlast) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PARSE_CFG_ERR_CNT_EN
  logic err_pulse;
  assign err_pulse = accept && (((state_q == StIdle) && claimed && s_ctrl_tlast) ||
                                ((state_q == StCap) && !s_ctrl_tlast));

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      cfg_err_cnt <= '0;
    end else if (err_pulse && (cfg_err_cnt != 16'hFFFF)) begin
      cfg_err_cnt <= cfg_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parse_act_cfg_ctrl.sv
// Scoreboard bench for parse_act_cfg_ctrl: expected beats/writes queued by stimulus, popped by monitor.
module tb_parse_act_cfg_ctrl;

  logic         axis_clk = 1'b0;
  logic         areset;
  logic [255:0] s_ctrl_tdata;
  logic [31:0]  s_ctrl_tkeep;
  logic         s_ctrl_tvalid;
  logic         s_ctrl_tlast;
  logic         s_ctrl_tready;
  logic [255:0] m_ctrl_tdata;
  logic [31:0]  m_ctrl_tkeep;
  logic         m_ctrl_tvalid;
  logic         m_ctrl_tlast;
  logic         m_ctrl_tready;
  logic         parser_busy;
  logic [3:0]   ram_addr;
  logic [259:0] ram_din;
  logic         ram_en;
  logic         ram_we;
`ifdef PARSE_CFG_ERR_CNT_EN
  logic [15:0]  cfg_err_cnt;
`endif

  parse_act_cfg_ctrl dut (
    .axis_clk      (axis_clk),
    .areset        (areset),
    .s_ctrl_tdata  (s_ctrl_tdata),
    .s_ctrl_tkeep  (s_ctrl_tkeep),
    .s_ctrl_tvalid (s_ctrl_tvalid),
    .s_ctrl_tlast  (s_ctrl_tlast),
    .s_ctrl_tready (s_ctrl_tready),
    .m_ctrl_tdata  (m_ctrl_tdata),
    .m_ctrl_tkeep  (m_ctrl_tkeep),
    .m_ctrl_tvalid (m_ctrl_tvalid),
    .m_ctrl_tlast  (m_ctrl_tlast),
    .m_ctrl_tready (m_ctrl_tready),
    .parser_busy   (parser_busy),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_en        (ram_en),
    .ram_we        (ram_we)
`ifdef PARSE_CFG_ERR_CNT_EN
    ,
    .cfg_err_cnt   (cfg_err_cnt)
`endif
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  typedef struct {
    logic [3:0]   addr;
    logic [259:0] din;
  } wr_t;

  beat_t fwd_q[$];
  wr_t   ram_q[$];
  int    vectors = 0;
  int    errors  = 0;
  logic  tog_mode = 1'b0;

  localparam logic [259:0] P1 = {4'h5, {8{32'h1234_5678}}};
  localparam logic [259:0] P2 = {4'hC, {4{64'h0123_4567_89AB_CDEF}}};
  localparam logic [259:0] P3 = {4'h9, {8{32'hA5C3_0F1E}}};

  task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] cfg_beat0(input logic [7:0] id, input logic [3:0] op,
                                             input logic [3:0] idx, input logic [259:0] e);
    return {e[223:0], 16'h0000, op, idx, id};
  endfunction

  function automatic logic [255:0] cfg_beat1(input logic [259:0] e);
    return {220'h0BAD_F00D, e[259:224]};
  endfunction

  // Downstream ready: held high, or toggled every cycle when tog_mode is set.
  always @(posedge axis_clk) begin
    #1;
    if (tog_mode) m_ctrl_tready = ~m_ctrl_tready;
    else          m_ctrl_tready = 1'b1;
  end

  // Monitor
  always @(negedge axis_clk) begin
    if (areset === 1'b0) begin
      if (m_ctrl_tvalid && m_ctrl_tready) begin
        if (fwd_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_fwd: got beat %h expected none", m_ctrl_tdata);
        end else begin
          beat_t b;
          b = fwd_q.pop_front();
          chk("fwd_data", {4'h0, m_ctrl_tdata}, {4'h0, b.data});
          chk("fwd_keep", {228'h0, m_ctrl_tkeep}, {228'h0, b.keep});
          chk("fwd_last", {259'h0, m_ctrl_tlast}, {259'h0, b.last});
        end
      end
      if (ram_we) begin
        if (ram_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_ram_we: got addr %0d expected no write", ram_addr);
        end else begin
          wr_t w;
          w = ram_q.pop_front();
          chk("ram_addr", {256'h0, ram_addr}, {256'h0, w.addr});
          chk("ram_din", ram_din, w.din);
          chk("ram_en_with_we", {259'h0, ram_en}, 260'h1);
          chk("busy_at_write", {259'h0, parser_busy}, 260'h0);
        end
      end
    end
  end

  task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l);
    int   n;
    logic rdy;
    s_ctrl_tdata  = d;
    s_ctrl_tkeep  = k;
    s_ctrl_tlast  = l;
    s_ctrl_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge axis_clk);
      rdy = s_ctrl_tready;
      @(posedge axis_clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        vectors++; errors++;
        $display("FAIL send_timeout: got no tready expected accept within 200 cycles");
        break;
      end
    end
  endtask

  task automatic fwd(input logic [255:0] d, input logic [31:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    fwd_q.push_back(b);
    send(d, k, l);
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [259:0] e);
    wr_t w;
    w.addr = a; w.din = e;
    ram_q.push_back(w);
  endtask

  task automatic idle(input int cycles);
    s_ctrl_tvalid = 1'b0;
    repeat (cycles) @(posedge axis_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1;
    s_ctrl_tdata = '0; s_ctrl_tkeep = '0; s_ctrl_tvalid = 1'b0; s_ctrl_tlast = 1'b0;
    parser_busy = 1'b0;
    repeat (3) @(posedge axis_clk);
    #1 areset = 1'b0;

    // Reset state
    chk("rst_m_tvalid", {259'h0, m_ctrl_tvalid}, 260'h0);
    chk("rst_ram_en", {259'h0, ram_en}, 260'h0);
    chk("rst_ram_we", {259'h0, ram_we}, 260'h0);
    chk("rst_ram_addr", {256'h0, ram_addr}, 260'h0);
    chk("rst_ram_din", ram_din, 260'h0);
    chk("rst_s_tready", {259'h0, s_ctrl_tready}, 260'h1);
`ifdef PARSE_CFG_ERR_CNT_EN
    chk("rst_err_cnt", {244'h0, cfg_err_cnt}, 260'h0);
`endif

    // 1: plain claimed write
    expect_wr(4'h3, P1);
    send(cfg_beat0(8'h01, 4'h0, 4'h3, P1), '1, 1'b0);
    send(cfg_beat1(P1), '1, 1'b1);
    idle(4);

    // 2: write deferred by parser_busy
    expect_wr(4'h3, P1);
    send(cfg_beat0(8'h01, 4'h0, 4'h3, P1), '1, 1'b0);
    parser_busy = 1'b1;
    send(cfg_beat1(P1), '1, 1'b1);
    s_ctrl_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_clk);
      chk("busy_tready", {259'h0, s_ctrl_tready}, 260'h0);
      chk("busy_no_we", {259'h0, ram_we}, 260'h0);
      @(posedge axis_clk);
      #1;
    end
    parser_busy = 1'b0;
    idle(4);

    // 3: foreign packet through toggling downstream ready
    tog_mode = 1'b1;
    fwd({{31{8'h11}}, 8'h02}, 32'hFFFF_FFFF, 1'b0);
    fwd({{31{8'h22}}, 8'h02}, 32'h0000_FFFF, 1'b0);
    fwd({{31{8'h33}}, 8'h02}, 32'h0000_000F, 1'b1);
    idle(8);
    tog_mode = 1'b0;
    idle(2);

    // 4: malformed claimed packets, then a good write
    send(cfg_beat0(8'h01, 4'h0, 4'h1, P2), '1, 1'b1);
    send(cfg_beat0(8'h01, 4'h0, 4'h2, P2), '1, 1'b0);
    send(cfg_beat1(P2), '1, 1'b0);
    send(cfg_beat1(P2), '1, 1'b1);
    idle(3);
`ifdef PARSE_CFG_ERR_CNT_EN
    chk("err_cnt", {244'h0, cfg_err_cnt}, 260'h2);
`endif
    expect_wr(4'h7, P2);
    send(cfg_beat0(8'h01, 4'h0, 4'h7, P2), '1, 1'b0);
    send(cfg_beat1(P2), '1, 1'b1);
    idle(4);

    // 5: back-to-back forward / write / forward (opcode 1 is not a write, so forwarded)
    fwd({{31{8'h44}}, 8'h05}, 32'hFFFF_FFFF, 1'b0);
    fwd({{31{8'h55}}, 8'h05}, 32'h00FF_00FF, 1'b1);
    expect_wr(4'hF, P3);
    send(cfg_beat0(8'h01, 4'h0, 4'hF, P3), '1, 1'b0);
    send(cfg_beat1(P3), '1, 1'b1);
    fwd({{30{8'h66}}, 8'h10, 8'h01}, 32'h0000_0001, 1'b1);
    idle(6);

    // 6: reset while capturing
    send(cfg_beat0(8'h01, 4'h0, 4'h9, P2), '1, 1'b0);
    s_ctrl_tvalid = 1'b0;
    areset = 1'b1;
    @(posedge axis_clk);
    #1;
    chk("rst6_ram_we", {259'h0, ram_we}, 260'h0);
    chk("rst6_m_tvalid", {259'h0, m_ctrl_tvalid}, 260'h0);
    chk("rst6_m_tdata", {4'h0, m_ctrl_tdata}, 260'h0);
    areset = 1'b0;
    fwd({{31{8'h77}}, 8'h02}, 32'hFFFF_FFFF, 1'b1);
    idle(6);

    chk("fwd_q_drained", fwd_q.size(), 260'h0);
    chk("ram_q_drained", ram_q.size(), 260'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
